// File: rtl/password_vault_pkg.sv
// Shared types and constants for the password vault: FSM states, entry kinds
// and the power-on password value.
package password_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ENTRY   = 2'd1,
    S_LOCKOUT = 2'd2
  } state_e;

  typedef enum logic {
    KIND_VERIFY = 1'b0,
    KIND_PROG   = 1'b1
  } kind_e;

  // Replicated across the full password width by the vault.
  localparam logic DEFAULT_PW_BIT = 1'b0;

endpackage

// File: rtl/password_vault_lockout_timer.sv
// Down-counter that holds the vault in lockout for LOCK_CYCLES clocks after a
// start request; last_o flags the final lockout cycle.
module lockout_timer #(
  parameter int LOCK_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  output logic active_o,
  output logic last_o
);

  localparam int CW = $clog2(LOCK_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = CW'(LOCK_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign active_o = (cnt_q != '0);
  assign last_o   = (cnt_q == CW'(1));

endmodule

// File: rtl/password_vault.sv
// Keypad password store: collects digits MSB-first, verifies or programs the
// stored password, and locks out after MAX_TRIES consecutive failures.
module password_vault
  import password_pkg::*;
#(
  parameter int DIGIT_W     = 4,
  parameter int DIGITS      = 4,
  parameter int MAX_TRIES   = 3,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DIGIT_W-1:0]               digit_in,
  input  logic                             digit_valid,
  input  logic                             prog_req,
  input  logic                             clear,
  input  logic                             relock,
  output logic                             open,
  output logic                             match_pulse,
  output logic                             fail_pulse,
  output logic                             prog_done,
  output logic                             locked,
  output logic [$clog2(DIGITS+1)-1:0]      entry_cnt,
  output logic [$clog2(MAX_TRIES+1)-1:0]   tries_left
);

  localparam int PW    = DIGITS * DIGIT_W;
  localparam int CNT_W = $clog2(DIGITS + 1);
  localparam int TRY_W = $clog2(MAX_TRIES + 1);

  state_e             state_q, state_d;
  kind_e              kind_q, kind_d;
  logic [PW-1:0]      stored_q, stored_d;
  logic [PW-1:0]      entry_q, entry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TRY_W-1:0]   tries_q, tries_d;
  logic               open_q, open_d;
  logic               match_q, match_d;
  logic               fail_q, fail_d;
  logic               prog_done_q, prog_done_d;

  logic               complete;
  logic [PW-1:0]      done_entry;
  kind_e              done_kind;
  logic               lock_start;
  logic               tmr_active, tmr_last;

  lockout_timer #(.LOCK_CYCLES(LOCK_CYCLES)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .start_i  (lock_start),
    .active_o (tmr_active),
    .last_o   (tmr_last)
  );

  // NOTE: every signal assigned here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    stored_d    = stored_q;
    entry_d     = entry_q;
    cnt_d       = cnt_q;
    tries_d     = tries_q;
    open_d      = open_q;
    match_d     = 1'b0;
    fail_d      = 1'b0;
    prog_done_d = 1'b0;
    complete    = 1'b0;
    done_entry  = '0;
    done_kind   = kind_q;
    lock_start  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (digit_valid && !clear) begin
          entry_d = PW'(digit_in);
          cnt_d   = CNT_W'(1);
          kind_d  = (prog_req && open_q) ? KIND_PROG : KIND_VERIFY;
          state_d = S_ENTRY;
          if (DIGITS == 1) begin
            complete   = 1'b1;
            done_entry = entry_d;
            done_kind  = kind_d;
          end
        end
      end
      S_ENTRY: begin
        if (clear) begin
          entry_d = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (digit_valid) begin
          entry_d = (entry_q << DIGIT_W) | PW'(digit_in);
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DIGITS - 1)) begin
            complete   = 1'b1;
            done_entry = entry_d;
          end
        end
      end
      S_LOCKOUT: begin
        if (tmr_last) begin
          state_d = S_IDLE;
          tries_d = TRY_W'(MAX_TRIES);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (complete) begin
      entry_d = '0;
      cnt_d   = '0;
      state_d = S_IDLE;
      if (done_kind == KIND_PROG) begin
        // A program entry only commits if the vault stayed open throughout.
        if (open_q) begin
          stored_d    = done_entry;
          prog_done_d = 1'b1;
        end
      end else if (done_entry == stored_q) begin
        match_d = 1'b1;
        open_d  = 1'b1;
        tries_d = TRY_W'(MAX_TRIES);
      end else begin
        fail_d  = 1'b1;
        tries_d = tries_q - TRY_W'(1);
        if (tries_q == TRY_W'(1)) begin
          state_d    = S_LOCKOUT;
          lock_start = 1'b1;
          open_d     = 1'b0;
        end
      end
    end

    if (relock) begin
      open_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      kind_q      <= KIND_VERIFY;
      stored_q    <= {PW{DEFAULT_PW_BIT}};
      entry_q     <= '0;
      cnt_q       <= '0;
      tries_q     <= TRY_W'(MAX_TRIES);
      open_q      <= 1'b0;
      match_q     <= 1'b0;
      fail_q      <= 1'b0;
      prog_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      stored_q    <= stored_d;
      entry_q     <= entry_d;
      cnt_q       <= cnt_d;
      tries_q     <= tries_d;
      open_q      <= open_d;
      match_q     <= match_d;
      fail_q      <= fail_d;
      prog_done_q <= prog_done_d;
    end
  end

  assign open        = open_q;
  assign match_pulse = match_q;
  assign fail_pulse  = fail_q;
  assign prog_done   = prog_done_q;
  assign locked      = tmr_active;
  assign entry_cnt   = cnt_q;
  assign tries_left  = tries_q;

endmodule

// File: tb/tb_password_vault.sv
// Self-checking bench for password_vault: directed scenarios from the feature
// list plus a randomized run against a digit-queue reference model.
module tb_password_vault;

  localparam int DIGIT_W     = 4;
  localparam int DIGITS      = 4;
  localparam int MAX_TRIES   = 3;
  localparam int LOCK_CYCLES = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] digit_in = '0;
  logic       digit_valid = 1'b0;
  logic       prog_req = 1'b0;
  logic       clear = 1'b0;
  logic       relock = 1'b0;
  logic       open, match_pulse, fail_pulse, prog_done, locked;
  logic [2:0] entry_cnt;
  logic [1:0] tries_left;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state.
  int  m_stored;
  int  m_entry[$];
  bit  m_open, m_prog, m_match, m_fail, m_pdone;
  int  m_tries;
  int  m_lock;

  password_vault #(
    .DIGIT_W(DIGIT_W), .DIGITS(DIGITS), .MAX_TRIES(MAX_TRIES), .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .digit_in(digit_in), .digit_valid(digit_valid),
    .prog_req(prog_req), .clear(clear), .relock(relock), .open(open),
    .match_pulse(match_pulse), .fail_pulse(fail_pulse), .prog_done(prog_done),
    .locked(locked), .entry_cnt(entry_cnt), .tries_left(tries_left)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic model_edge(input logic r, input logic dv, input logic [3:0] d,
                            input logic pr, input logic clr, input logic rl);
    bit nopen;
    int v;
    m_match = 0; m_fail = 0; m_pdone = 0;
    if (!r) begin
      m_stored = 0; m_entry.delete(); m_open = 0; m_tries = MAX_TRIES; m_lock = 0;
      return;
    end
    nopen = m_open;
    if (m_lock > 0) begin
      m_lock--;
      if (m_lock == 0) m_tries = MAX_TRIES;
    end else if (clr) begin
      m_entry.delete();
    end else if (dv) begin
      if (m_entry.size() == 0) m_prog = pr && m_open;
      m_entry.push_back(int'(d));
      if (m_entry.size() == DIGITS) begin
        v = 0;
        foreach (m_entry[i]) v = v * (1 << DIGIT_W) + m_entry[i];
        if (m_prog) begin
          if (m_open) begin m_stored = v; m_pdone = 1; end
        end else if (v == m_stored) begin
          m_match = 1; nopen = 1; m_tries = MAX_TRIES;
        end else begin
          m_fail = 1; m_tries--;
          if (m_tries == 0) begin m_lock = LOCK_CYCLES; nopen = 0; end
        end
        m_entry.delete();
      end
    end
    if (rl) nopen = 0;
    m_open = nopen;
  endtask

  // Drive one cycle of inputs, clock it, advance the model, sample after the edge.
  task automatic step(input logic r, input logic dv, input logic [3:0] d,
                      input logic pr, input logic clr, input logic rl);
    @(negedge clk);
    rst = r; digit_valid = dv; digit_in = d; prog_req = pr; clear = clr; relock = rl;
    @(posedge clk);
    model_edge(r, dv, d, pr, clr, rl);
    #1;
  endtask

  task automatic idle();
    step(1, 0, 4'd0, 0, 0, 0);
  endtask

  task automatic enter(input logic [15:0] code, input logic pr);
    for (int i = 0; i < DIGITS; i++) step(1, 1, code[(3-i)*4 +: 4], pr, 0, 0);
  endtask

  task automatic test_reset();
    step(0, 0, 4'd0, 0, 0, 0);
    step(0, 1, 4'd5, 1, 0, 0);
    tests_run++;
    if ({open, locked, match_pulse, fail_pulse, prog_done, entry_cnt, tries_left} !== {5'b0, 3'd0, 2'd3}) begin
      tests_failed++;
      $display("FAIL reset_state: got %b want %b",
               {open, locked, match_pulse, fail_pulse, prog_done, entry_cnt, tries_left}, {5'b0, 3'd0, 2'd3});
    end
  endtask

  task automatic test_verify_default();
    enter(16'h0000, 0);
    tests_run++;
    if ({match_pulse, fail_pulse, open, tries_left, entry_cnt} !== {3'b101, 2'd3, 3'd0}) begin
      tests_failed++;
      $display("FAIL verify_default: got %b want %b", {match_pulse, fail_pulse, open, tries_left, entry_cnt}, {3'b101, 2'd3, 3'd0});
    end
    idle();
    tests_run++;
    if ({match_pulse, open} !== 2'b01) begin
      tests_failed++;
      $display("FAIL match_one_cycle: got %b want 01", {match_pulse, open});
    end
  endtask

  task automatic test_program();
    enter(16'h1234, 1);
    tests_run++;
    if ({prog_done, match_pulse, open} !== 3'b101) begin
      tests_failed++;
      $display("FAIL program_commit: got %b want 101", {prog_done, match_pulse, open});
    end
    step(1, 0, 4'd0, 0, 0, 1);
    tests_run++;
    if ({prog_done, open} !== 2'b00) begin
      tests_failed++;
      $display("FAIL relock_clears_open: got %b want 00", {prog_done, open});
    end
    enter(16'h0000, 0);
    tests_run++;
    if ({fail_pulse, match_pulse, tries_left} !== {2'b10, 2'd2}) begin
      tests_failed++;
      $display("FAIL old_pw_rejected: got %b want %b", {fail_pulse, match_pulse, tries_left}, {2'b10, 2'd2});
    end
    enter(16'h1234, 0);
    tests_run++;
    if ({match_pulse, open, tries_left} !== {2'b11, 2'd3}) begin
      tests_failed++;
      $display("FAIL new_pw_accepted: got %b want %b", {match_pulse, open, tries_left}, {2'b11, 2'd3});
    end
  endtask

  task automatic test_lockout();
    step(1, 0, 4'd0, 0, 0, 1);
    enter(16'h9999, 0);
    enter(16'h9999, 0);
    enter(16'h9999, 0);
    tests_run++;
    if ({fail_pulse, locked, open, tries_left} !== {3'b110, 2'd0}) begin
      tests_failed++;
      $display("FAIL lockout_entry: got %b want %b", {fail_pulse, locked, open, tries_left}, {3'b110, 2'd0});
    end
    for (int i = 1; i < LOCK_CYCLES; i++) begin
      step(1, 1, 4'($urandom_range(0, 15)), 1, i % 3 == 0, 0);
      tests_run++;
      if ({locked, entry_cnt} !== {1'b1, 3'd0}) begin
        tests_failed++;
        $display("FAIL lockout_hold_%0d: got %b want %b", i, {locked, entry_cnt}, {1'b1, 3'd0});
      end
    end
    step(1, 1, 4'd7, 0, 0, 0);
    tests_run++;
    if ({locked, entry_cnt, tries_left} !== {1'b0, 3'd0, 2'd3}) begin
      tests_failed++;
      $display("FAIL lockout_exit: got %b want %b", {locked, entry_cnt, tries_left}, {1'b0, 3'd0, 2'd3});
    end
    step(1, 1, 4'd7, 0, 0, 0);
    tests_run++;
    if (entry_cnt !== 3'd1) begin
      tests_failed++;
      $display("FAIL first_digit_after_lockout: got %0d want 1", entry_cnt);
    end
    step(1, 0, 4'd0, 0, 1, 0);
  endtask

  task automatic test_clear();
    step(1, 1, 4'd1, 0, 0, 0);
    step(1, 1, 4'd2, 0, 0, 0);
    step(1, 1, 4'd3, 0, 1, 0);
    tests_run++;
    if ({entry_cnt, match_pulse, fail_pulse} !== {3'd0, 2'b00}) begin
      tests_failed++;
      $display("FAIL clear_beats_digit: got %b want %b", {entry_cnt, match_pulse, fail_pulse}, {3'd0, 2'b00});
    end
    enter(16'h1234, 0);
    tests_run++;
    if ({match_pulse, open} !== 2'b11) begin
      tests_failed++;
      $display("FAIL match_after_clear: got %b want 11", {match_pulse, open});
    end
  endtask

  task automatic test_relock_priority();
    step(1, 0, 4'd0, 0, 0, 1);
    step(1, 1, 4'd1, 0, 0, 0);
    step(1, 1, 4'd2, 0, 0, 0);
    step(1, 1, 4'd3, 0, 0, 0);
    step(1, 1, 4'd4, 0, 0, 1);
    tests_run++;
    if ({match_pulse, open} !== 2'b10) begin
      tests_failed++;
      $display("FAIL relock_beats_match: got %b want 10", {match_pulse, open});
    end
    enter(16'h1234, 0);
    step(1, 1, 4'd5, 1, 0, 0);
    step(1, 1, 4'd6, 1, 0, 0);
    step(1, 0, 4'd0, 0, 0, 1);
    step(1, 1, 4'd7, 0, 0, 0);
    step(1, 1, 4'd8, 0, 0, 0);
    tests_run++;
    if ({prog_done, match_pulse, fail_pulse, open, tries_left} !== {4'b0000, 2'd3}) begin
      tests_failed++;
      $display("FAIL prog_aborted_by_relock: got %b want %b", {prog_done, match_pulse, fail_pulse, open, tries_left}, {4'b0000, 2'd3});
    end
    enter(16'h1234, 0);
    tests_run++;
    if ({match_pulse, open} !== 2'b11) begin
      tests_failed++;
      $display("FAIL stored_unchanged: got %b want 11", {match_pulse, open});
    end
    enter(16'h5678, 0);
    tests_run++;
    if ({fail_pulse, open, tries_left} !== {2'b11, 2'd2}) begin
      tests_failed++;
      $display("FAIL aborted_pw_rejected: got %b want %b", {fail_pulse, open, tries_left}, {2'b11, 2'd2});
    end
  endtask

  task automatic test_reset_mid_entry();
    enter(16'h5678, 0);
    step(1, 1, 4'd1, 0, 0, 0);
    step(1, 1, 4'd2, 0, 0, 0);
    tests_run++;
    if ({open, tries_left, entry_cnt} !== {1'b1, 2'd1, 3'd2}) begin
      tests_failed++;
      $display("FAIL pre_reset_state: got %b want %b", {open, tries_left, entry_cnt}, {1'b1, 2'd1, 3'd2});
    end
    step(0, 1, 4'd3, 0, 0, 0);
    tests_run++;
    if ({entry_cnt, open, locked, tries_left} !== {3'd0, 2'b00, 2'd3}) begin
      tests_failed++;
      $display("FAIL mid_entry_reset: got %b want %b", {entry_cnt, open, locked, tries_left}, {3'd0, 2'b00, 2'd3});
    end
    enter(16'h0000, 0);
    tests_run++;
    if ({match_pulse, open} !== 2'b11) begin
      tests_failed++;
      $display("FAIL password_reverted: got %b want 11", {match_pulse, open});
    end
  endtask

  task automatic test_back_to_back();
    enter(16'h0000, 0);
    step(1, 1, 4'd0, 0, 0, 0);
    tests_run++;
    if ({match_pulse, entry_cnt} !== {1'b0, 3'd1}) begin
      tests_failed++;
      $display("FAIL digit_during_pulse: got %b want %b", {match_pulse, entry_cnt}, {1'b0, 3'd1});
    end
    step(1, 1, 4'd0, 0, 0, 0);
    step(1, 1, 4'd0, 0, 0, 0);
    step(1, 1, 4'd0, 0, 0, 0);
    tests_run++;
    if ({match_pulse, entry_cnt} !== {1'b1, 3'd0}) begin
      tests_failed++;
      $display("FAIL back_to_back_match: got %b want %b", {match_pulse, entry_cnt}, {1'b1, 3'd0});
    end
  endtask

  task automatic test_random();
    logic [9:0] obs, exp;
    logic       r, dv, pr, clr, rl;
    logic [3:0] d;
    step(0, 0, 4'd0, 0, 0, 0);
    for (int i = 0; i < 1500; i++) begin
      r   = ($urandom_range(0, 199) != 0);
      dv  = ($urandom_range(0, 99) < 60);
      d   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 1));
      pr  = ($urandom_range(0, 99) < 40);
      clr = ($urandom_range(0, 99) < 4);
      rl  = ($urandom_range(0, 99) < 4);
      step(r, dv, d, pr, clr, rl);
      obs = {open, match_pulse, fail_pulse, prog_done, locked, entry_cnt, tries_left};
      exp = {m_open, m_match, m_fail, m_pdone, (m_lock > 0), 3'(m_entry.size()), 2'(m_tries)};
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL random_cycle_%0d: got %b want %b (open,match,fail,prog,locked,cnt,tries)", i, obs, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_verify_default();
    test_program();
    test_lockout();
    test_clear();
    test_relock_priority();
    test_reset_mid_entry();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
